// File: rtl/mte_pkg.sv
// mte_pkg: shared state encoding and default sizing for the MTE stream controller
package mte_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, SEND} mte_ctrl_state_t;
   localparam int MTE_N = 8;
   localparam int MTE_MSG_BYTES = 4;
   localparam int MTE_PIPE_LAT = 2;
endpackage

// File: rtl/mte_lat_tag.sv
// mte_lat_tag: LAT-deep 1-bit delay line that marks when a core result byte is ready
module mte_lat_tag #(
   parameter int LAT = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic tag_in,
   output logic tag_out
);
   logic [LAT-1:0] sr;
   // shift one issue tag per clock; the oldest tag is the capture strobe
   always_ff @(posedge clock or posedge reset)
      if (reset) sr <= '0;
      else sr <= LAT'({sr, tag_in});
   assign tag_out = sr[LAT-1];
endmodule

// File: rtl/mte_stream_ctrl.sv
// mte_stream_ctrl: buffers a message, streams it through the MTE core and replays the results
module mte_stream_ctrl
   import mte_pkg::*;
#(
   parameter int N = MTE_N,
   parameter int MSG_BYTES = MTE_MSG_BYTES,
   parameter int PIPE_LAT = MTE_PIPE_LAT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [N-1:0] key_in,
   input  logic         mode_in,
   output logic [N-1:0] mte_key,
   output logic [N-1:0] mte_in,
   output logic         mte_sel,
   input  logic [N-1:0] mte_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last,
   output logic         busy
);
   localparam int CW = $clog2(MSG_BYTES + 1);
   localparam int D = 1 << CW;
   localparam logic [CW-1:0] LAST = CW'(MSG_BYTES - 1);
   localparam logic [CW-1:0] ONE = CW'(1);
   mte_ctrl_state_t state;
   logic [CW-1:0] ld_idx, is_idx, cap_idx, snd_idx;
   logic [N-1:0] ibuf [D];
   logic [N-1:0] obuf [D];
   logic cap;
   mte_lat_tag #(.LAT(PIPE_LAT)) u_tag (
      .clock(clock),
      .reset(reset),
      .tag_in(state == ISSUE),
      .tag_out(cap)
   );
   assign busy = state != IDLE;
   assign mte_in = state == ISSUE ? ibuf[is_idx] : '0;
   assign out_valid = state == SEND;
   assign out_data = out_valid ? obuf[snd_idx] : '0;
   assign out_last = out_valid && snd_idx == LAST;
   // message sequencer: load, issue, drain the core pipeline, then replay results
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         in_ready <= 1'b0;
         ld_idx <= '0;
         is_idx <= '0;
         cap_idx <= '0;
         snd_idx <= '0;
         mte_key <= '0;
         mte_sel <= 1'b0;
         for (int i = 0; i < D; i++) begin
            ibuf[i] <= '0;
            obuf[i] <= '0;
         end
      end else begin
         if (cap) begin
            obuf[cap_idx] <= mte_out;
            cap_idx <= cap_idx + ONE;
         end
         case (state)
            IDLE:
               if (in_valid && in_ready) begin
                  ibuf[0] <= in_data;
                  mte_key <= key_in;
                  mte_sel <= mode_in;
                  ld_idx <= ONE;
                  is_idx <= '0;
                  cap_idx <= '0;
                  snd_idx <= '0;
                  state <= MSG_BYTES == 1 ? ISSUE : LOAD;
                  in_ready <= MSG_BYTES != 1;
               end else in_ready <= 1'b1;
            LOAD:
               if (in_valid) begin
                  ibuf[ld_idx] <= in_data;
                  ld_idx <= ld_idx + ONE;
                  if (ld_idx == LAST) begin
                     state <= ISSUE;
                     in_ready <= 1'b0;
                  end
               end
            ISSUE: begin
               is_idx <= is_idx + ONE;
               if (is_idx == LAST) state <= DRAIN;
            end
            DRAIN:
               if (cap && cap_idx == LAST) state <= SEND;
            SEND:
               if (out_ready) begin
                  snd_idx <= snd_idx + ONE;
                  if (snd_idx == LAST) begin
                     state <= IDLE;
                     in_ready <= 1'b1;
                  end
               end
            default: state <= IDLE;
         endcase
      end
endmodule
